// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run/pause/clear sequencer for the six-digit decimal counter chain. Debounces
// the two active-low board keys, runs an IDLE/RUN/PAUSE machine and produces
// the single-cycle count-enable tick for the least-significant counter stage
// plus the single-cycle clear for the whole chain.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : a clr press while running toggles the lap-hold output 'frozen'
//   undefined : 'frozen' is tied low and a clr press while running is ignored
//
// Parameters
//   TICK_DIV      clk cycles per count tick (>= 2)
//   DEBOUNCE_CYC  consecutive stable cycles needed to accept a key level (>= 1)
//
// Ports
//   clk        system clock, single domain
//   rst_n      asynchronous active-low reset
//   key_run_n  run/pause key, active low, asynchronous to clk
//   key_clr_n  clear/lap key, active low, asynchronous to clk
//   tick_en    one-cycle count enable into the first counter's en
//   cnt_clr    one-cycle synchronous clear into every counter's clr
//   running    high while in RUN
//   frozen     lap-hold request to the display path
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 5_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_run_n,
  input  logic key_clr_n,
  output logic tick_en,
  output logic cnt_clr,
  output logic running,
  output logic frozen
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Bit 0 is the run key, bit 1 the clr key.
  logic [1:0] key_n;
  logic [1:0] press;

  assign key_n = {key_clr_n, key_run_n};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic            sync_p0;
    logic            sync_p1;
    logic            db;
    logic            db_p0;
    logic            press_q;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_p0 <= 1'b1;
        sync_p1 <= 1'b1;
        db      <= 1'b1;
        db_p0   <= 1'b1;
        press_q <= 1'b0;
        db_cnt  <= '0;
      end else begin
        // stage p0/p1: two-flop synchronizer
        sync_p0 <= key_n[g];
        sync_p1 <= sync_p0;

        // debounce: any return to the accepted level restarts the window
        if (sync_p1 == db) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db     <= sync_p1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end

        // press pulse on the accepted 1->0 transition only
        db_p0   <= db;
        press_q <= db_p0 & ~db;
      end
    end

    assign press[g] = press_q;
  end

  // A clr press always wins over a simultaneous run press.
  logic clr_press;
  logic run_press;

  assign clr_press = press[1];
  assign run_press = press[0] & ~press[1];

  state_t           state;
  logic [DIV_W-1:0] div;

`ifdef STOPWATCH_LAP_EN
  logic frozen_q;
  assign frozen = frozen_q;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div     <= '0;
      tick_en <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      frozen_q <= 1'b0;
`endif
    end else begin
      tick_en <= 1'b0;
      cnt_clr <= 1'b0;

      // divider only advances while running; it holds its phase otherwise
      if (state == ST_RUN) begin
        if (div == DIV_LAST) begin
          div     <= '0;
          tick_en <= 1'b1;
        end else begin
          div <= div + DIV_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (clr_press) begin
            cnt_clr <= 1'b1;
          end else if (run_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
            div     <= '0;
          end
        end

        ST_RUN: begin
          if (clr_press) begin
`ifdef STOPWATCH_LAP_EN
            frozen_q <= ~frozen_q;
`endif
          end else if (run_press) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end

        ST_PAUSE: begin
          if (clr_press) begin
            state   <= ST_IDLE;
            cnt_clr <= 1'b1;
`ifdef STOPWATCH_LAP_EN
            frozen_q <= 1'b0;
`endif
          end else if (run_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int TICK_DIV     = 5;
  localparam int DEBOUNCE_CYC = 4;
  // Key driven low at a negedge with cyc==c is first sampled at edge c+1;
  // the state changes at edge (c+1)+3+DEBOUNCE_CYC.
  localparam int KEY_LAT   = DEBOUNCE_CYC + 4;
  // A key released KEY_LAT cycles after being pressed is debounced high again
  // this many cycles after the press started.
  localparam int PRESS_GAP = KEY_LAT + DEBOUNCE_CYC + 2;

  logic clk;
  logic rst_n;
  logic key_run_n;
  logic key_clr_n;
  logic tick_en;
  logic cnt_clr;
  logic running;
  logic frozen;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ev_cnt = 0;

  typedef struct {
    int cyc;
    bit clr;
  } ev_t;

  ev_t sb_q[$];

  int t_run;
  int hold;
  int r_run;
  bit exp_frz;

  stopwatch_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_run_n(key_run_n),
    .key_clr_n(key_clr_n),
    .tick_en  (tick_en),
    .cnt_clr  (cnt_clr),
    .running  (running),
    .frozen   (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every tick_en / cnt_clr pulse must match the next expected event.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_event: expected %s at cycle %0d, nothing seen by cycle %0d",
               sb_q[0].clr ? "cnt_clr" : "tick_en", sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    if (tick_en === 1'b1 && cnt_clr === 1'b1) begin
      ev_cnt++;
      checks++;
      errors++;
      $display("FAIL tick_clr_overlap: tick_en and cnt_clr both high at cycle %0d, required exclusive", cyc);
    end else if (tick_en === 1'b1 || cnt_clr === 1'b1) begin
      ev_cnt++;
      checks++;
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        if (sb_q[0].clr !== cnt_clr) begin
          errors++;
          $display("FAIL event_kind: cycle %0d got cnt_clr=%0b tick_en=%0b, required %s",
                   cyc, cnt_clr, tick_en, sb_q[0].clr ? "cnt_clr" : "tick_en");
        end
        void'(sb_q.pop_front());
      end else begin
        errors++;
        $display("FAIL unexpected_event: cycle %0d got tick_en=%0b cnt_clr=%0b, required none",
                 cyc, tick_en, cnt_clr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, stopped at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push_ev(input int at, input bit is_clr);
    ev_t e;
    e.cyc = at;
    e.clr = is_clr;
    sb_q.push_back(e);
  endtask

  task automatic push_ticks(input int first, input int last);
    for (int t = first; t <= last; t += TICK_DIV) push_ev(t, 1'b0);
  endtask

  task automatic test_reset();
    int ev0;
    rst_n     = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ev0 = ev_cnt;
    wait_to(cyc + 100);
    checks++; if (tick_en !== 1'b0) begin errors++; $display("FAIL reset_tick_en: got %0b, required 0", tick_en); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr: got %0b, required 0", cnt_clr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b, required 0", running); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got %0b, required 0", frozen); end
    checks++; if (ev_cnt !== ev0) begin errors++; $display("FAIL reset_no_events: got %0d events, required 0", ev_cnt - ev0); end
  endtask

  task automatic test_glitch();
    int c;
    int ev0;
    c   = cyc;
    ev0 = ev_cnt;
    key_run_n = 1'b0;
    wait_to(c + 3);
    key_run_n = 1'b1;
    wait_to(c + 25);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL glitch_running: got %0b, required 0", running); end
    checks++; if (ev_cnt !== ev0) begin errors++; $display("FAIL glitch_events: got %0d events, required 0", ev_cnt - ev0); end
  endtask

  task automatic test_run();
    int c;
    c     = cyc;
    t_run = c + KEY_LAT;
    key_run_n = 1'b0;
    // First tick TICK_DIV cycles after the transition; window ends before the pause edge.
    push_ticks(t_run + TICK_DIV, t_run + 21);
    wait_to(t_run - 1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_early: running=%0b one cycle before entry, required 0", running); end
    wait_to(t_run);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_entry: running=%0b at entry edge, required 1", running); end
    key_run_n = 1'b1;
  endtask

  task automatic test_pause_resume();
    int c;
    int p;
    int ev0;
    // Pause edge placed two cycles after a tick so the divider is held at 2.
    c = t_run + 14;
    p = c + KEY_LAT;
    hold = (p - t_run) % TICK_DIV;
    wait_to(c);
    key_run_n = 1'b0;
    wait_to(p - 1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_early: running=%0b, required 1", running); end
    wait_to(p);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_entry: running=%0b, required 0", running); end
    key_run_n = 1'b1;
    ev0 = ev_cnt;
    wait_to(p + 50);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_hold: running=%0b, required 0", running); end
    checks++; if (ev_cnt !== ev0) begin errors++; $display("FAIL pause_no_tick: got %0d events while paused, required 0", ev_cnt - ev0); end

    c = cyc;
    r_run = c + KEY_LAT;
    key_run_n = 1'b0;
    // Divider resumes from its held value: remaining TICK_DIV-hold cycles.
    push_ticks(r_run + TICK_DIV - hold, r_run + 14);
    wait_to(r_run);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_entry: running=%0b, required 1", running); end
    key_run_n = 1'b1;

    // Pause again (no tick lands on this edge) to set up the clear test.
    c = r_run + 7;
    p = c + KEY_LAT;
    wait_to(c);
    key_run_n = 1'b0;
    wait_to(p);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL repause: running=%0b, required 0", running); end
    key_run_n = 1'b1;
  endtask

  task automatic test_clear();
    int c;
    c = cyc + 6;
    wait_to(c);
    key_clr_n = 1'b0;
    push_ev(c + KEY_LAT, 1'b1);
    wait_to(c + KEY_LAT);
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL pause_clr_pulse: cnt_clr=%0b, required 1", cnt_clr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_clr_running: running=%0b, required 0", running); end
    key_clr_n = 1'b1;
    wait_to(c + KEY_LAT + 2);
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL pause_clr_single: cnt_clr=%0b, required 0", cnt_clr); end

    // Clear again from IDLE: one pulse, still idle.
    c = c + PRESS_GAP;
    wait_to(c);
    key_clr_n = 1'b0;
    push_ev(c + KEY_LAT, 1'b1);
    wait_to(c + KEY_LAT);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_clr_running: running=%0b, required 0", running); end
    key_clr_n = 1'b1;
    wait_to(c + KEY_LAT + 2);
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL idle_clr_single: cnt_clr=%0b, required 0", cnt_clr); end
  endtask

  task automatic test_back_to_back();
    int c;
    int t2;
    int p;
    // Entry from IDLE zeroes the divider, so first tick is a full period later.
    c  = cyc + PRESS_GAP;
    t2 = c + KEY_LAT;
    wait_to(c);
    key_run_n = 1'b0;
    push_ticks(t2 + TICK_DIV, t2 + 13);
    wait_to(t2);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL b2b_run: running=%0b, required 1", running); end
    key_run_n = 1'b1;
    c = t2 + 6;
    p = c + KEY_LAT;
    wait_to(c);
    key_run_n = 1'b0;
    wait_to(p);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL b2b_pause: running=%0b, required 0", running); end
    key_run_n = 1'b1;

    // Both keys in the same cycle while paused: clear wins.
    c = p + 6;
    wait_to(c);
    key_run_n = 1'b0;
    key_clr_n = 1'b0;
    push_ev(c + KEY_LAT, 1'b1);
    wait_to(c + KEY_LAT);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL both_running: running=%0b, required 0", running); end
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    wait_to(c + KEY_LAT + 20);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL both_stays_idle: running=%0b, required 0", running); end
  endtask

  task automatic test_lap();
    int c;
    int t3;
    int l1;
    int l2;
`ifdef STOPWATCH_LAP_EN
    exp_frz = 1'b1;
`else
    exp_frz = 1'b0;
`endif
    c  = cyc;
    t3 = c + KEY_LAT;
    key_run_n = 1'b0;
    push_ticks(t3 + TICK_DIV, t3 + 30);
    wait_to(t3);
    key_run_n = 1'b1;
    c  = t3 + 1;
    l1 = c + KEY_LAT;
    wait_to(c);
    key_clr_n = 1'b0;
    wait_to(l1 - 1);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL lap_before: frozen=%0b, required 0", frozen); end
    wait_to(l1);
    checks++; if (frozen !== exp_frz) begin errors++; $display("FAIL lap_first: frozen=%0b, required %0b", frozen, exp_frz); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running: running=%0b, required 1", running); end
    key_clr_n = 1'b1;
    c  = c + PRESS_GAP;
    l2 = c + KEY_LAT;
    wait_to(c);
    key_clr_n = 1'b0;
    wait_to(l2 - 1);
    checks++; if (frozen !== exp_frz) begin errors++; $display("FAIL lap_hold: frozen=%0b, required %0b", frozen, exp_frz); end
    wait_to(l2);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL lap_second: frozen=%0b, required 0", frozen); end
    key_clr_n = 1'b1;
    wait_to(t3 + 32);
  endtask

  task automatic test_reset_mid_run();
    int ev0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrst_pre: running=%0b, required 1", running); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_running: running=%0b, required 0", running); end
    checks++; if (tick_en !== 1'b0) begin errors++; $display("FAIL midrst_tick_en: tick_en=%0b, required 0", tick_en); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL midrst_cnt_clr: cnt_clr=%0b, required 0", cnt_clr); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL midrst_frozen: frozen=%0b, required 0", frozen); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ev0 = ev_cnt;
    wait_to(cyc + 20);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL postrst_running: running=%0b, required 0", running); end
    checks++; if (ev_cnt !== ev0) begin errors++; $display("FAIL postrst_events: got %0d events, required 0", ev_cnt - ev0); end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
    test_reset();
    test_glitch();
    test_run();
    test_pause_resume();
    test_clear();
    test_back_to_back();
    test_lap();
    test_reset_mid_run();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
